// File: rtl/mux_n_1_reg.sv
// mux_n_1_reg: N-to-1 channel multiplexer with a registered, flow-controlled
// output stage and an optional round-robin scan engine.
//
// Build option: define MUX_SCAN_EN to compile in scan mode (mode, ch_mask,
// scan FSM and channel pointer). Without it only manual selection exists and
// mode/ch_mask are accepted but ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   i          channel data, channel k at [k*WIDTH +: WIDTH]
//   sel        manual channel select
//   sel_valid  manual capture request
//   mode       0 = manual, 1 = scan
//   ch_mask    per-channel scan enable
//   out_ready  downstream accept
//   f          registered selected data
//   f_ch       channel index of the data in f
//   f_valid    f/f_ch hold a valid sample
module mux_n_1_reg #(
  parameter int WIDTH = 1,
  parameter int N     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N*WIDTH-1:0]     i,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic                   sel_valid,
  input  logic                   mode,
  input  logic [N-1:0]           ch_mask,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       f,
  output logic [$clog2(N)-1:0]   f_ch,
  output logic                   f_valid
);

  localparam int SELW = $clog2(N);

  logic             free;
  logic             man_hit;
  logic             cap;
  logic [SELW-1:0]  cap_ch;
  logic [WIDTH-1:0] cap_data;

  // Output register may take a new sample when empty or being drained.
  assign free = !f_valid || out_ready;

`ifdef MUX_SCAN_EN
  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] first_ptr;
  logic [SELW-1:0] eff_ptr;
  logic [SELW-1:0] after_eff;
  logic            scan_req;
  logic            scan_sel;

  // Lowest set mask bit strictly above p; wraps to the lowest set bit.
  function automatic logic [SELW-1:0] next_set(input logic [N-1:0] m, input int p);
    logic [SELW-1:0] lo;
    logic [SELW-1:0] hi;
    logic            got_lo;
    logic            got_hi;
    lo     = '0;
    hi     = '0;
    got_lo = 1'b0;
    got_hi = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        if (!got_lo) begin
          lo     = SELW'(k);
          got_lo = 1'b1;
        end
        if (!got_hi && (k > p)) begin
          hi     = SELW'(k);
          got_hi = 1'b1;
        end
      end
    end
    return got_hi ? hi : lo;
  endfunction

  assign scan_req  = mode && (ch_mask != '0);
  assign scan_sel  = (state == SCAN) && scan_req;
  assign first_ptr = next_set(ch_mask, -1);
  // A pointer whose channel was masked off meanwhile is skipped before capture.
  assign eff_ptr   = ch_mask[ptr] ? ptr : next_set(ch_mask, int'(ptr));
  assign after_eff = next_set(ch_mask, int'(eff_ptr));
  assign man_hit   = !mode && sel_valid && (int'(sel) < N);
  assign cap       = scan_sel || man_hit;
  assign cap_ch    = scan_sel ? eff_ptr : sel;

  // Scan FSM and channel pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_req) begin
            state <= SCAN;
            ptr   <= first_ptr;
          end
        end
        SCAN: begin
          if (!scan_req) begin
            state <= IDLE;
          end else if (free) begin
            ptr <= after_eff;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_scan;

  assign unused_scan = ^{mode, ch_mask};
  assign man_hit     = sel_valid && (int'(sel) < N);
  assign cap         = man_hit;
  assign cap_ch      = sel;
`endif

  assign cap_data = i[int'(cap_ch)*WIDTH +: WIDTH];

  // Output register: capture when free, drain to invalid otherwise, hold on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f       <= '0;
      f_ch    <= '0;
      f_valid <= 1'b0;
    end else if (free) begin
      if (cap) begin
        f       <= cap_data;
        f_ch    <= cap_ch;
        f_valid <= 1'b1;
      end else begin
        f_valid <= 1'b0;
      end
    end
  end

endmodule
